// File: rtl/multiplier_sequential_pkg.sv
// ----------------------------------------------------------------------------
// multiplier_sequential_pkg
//   Shared definitions for the sequential shift-and-add multiplier.
//   Holds the FSM state encodings and width, the state enum, and a helper
//   that sizes the iteration counter.
// ----------------------------------------------------------------------------
package multiplier_sequential_pkg;

    // State encodings. 2'd3 is unused and recovers to idle.
    localparam int unsigned      MUL_STATE_W = 2;
    localparam logic [1:0]       MUL_IDLE    = 2'd0;
    localparam logic [1:0]       MUL_RUN     = 2'd1;
    localparam logic [1:0]       MUL_DONE    = 2'd2;

    typedef enum logic [MUL_STATE_W-1:0] {
        StIdle = MUL_IDLE,
        StRun  = MUL_RUN,
        StDone = MUL_DONE
    } mul_state_e;

    // One bit wider than strictly needed, so the counter can never wrap
    // before it reaches the terminal count.
    function automatic int unsigned count_width(input int unsigned iterations);
        return $clog2(iterations) + 1;
    endfunction

endpackage

// File: rtl/adder_full_1bit.sv
// ----------------------------------------------------------------------------
// adder_full_1bit
//   Single-bit full adder; the cell of the ripple-carry chain.
// Ports
//   carry_out  out  carry produced by this bit
//   sum        out  sum bit
//   a, b       in   addend bits
//   carry_in   in   carry from the previous bit
// ----------------------------------------------------------------------------
module adder_full_1bit (
    output logic carry_out,
    output logic sum,
    input  logic a,
    input  logic b,
    input  logic carry_in
);

    assign sum       = a ^ b ^ carry_in;
    assign carry_out = (a & b) | (carry_in & (a ^ b));

endmodule

// File: rtl/adder_ripple_nbit.sv
// ----------------------------------------------------------------------------
// adder_ripple_nbit
//   WIDTH-bit ripple-carry adder built from a chain of adder_full_1bit cells.
// Parameters
//   WIDTH      operand width in bits (>=1)
// Ports
//   carry_out  out  carry out of the most significant bit
//   sum        out  WIDTH-bit sum
//   a, b       in   WIDTH-bit addends
//   carry_in   in   carry into the least significant bit
// ----------------------------------------------------------------------------
module adder_ripple_nbit #(
    parameter int unsigned WIDTH = 8
) (
    output logic             carry_out,
    output logic [WIDTH-1:0] sum,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in
);

    logic [WIDTH:0] carry;

    assign carry[0]  = carry_in;
    assign carry_out = carry[WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        adder_full_1bit u_fa (
            .carry_out (carry[i+1]),
            .sum       (sum[i]),
            .a         (a[i]),
            .b         (b[i]),
            .carry_in  (carry[i])
        );
    end

endmodule

// File: rtl/multiplier_sequential.sv
// ----------------------------------------------------------------------------
// multiplier_sequential
//   Unsigned shift-and-add multiplier, MCAND_WIDTH x MPLIER_WIDTH. Retires one
//   multiplier bit per clock through a single ripple adder.
//   Start accepted at edge k -> done pulses and product is valid after edge
//   k+MPLIER_WIDTH. Starting again while done is high runs back-to-back.
// Parameters
//   MCAND_WIDTH   multiplicand width (>=2)
//   MPLIER_WIDTH  multiplier width (>=2), equals iterations per operation
// Ports
//   clock         in   rising-edge clock
//   reset         in   synchronous, active-high
//   start         in   request; sampled only in idle or done
//   multiplicand  in   operand A, captured on acceptance
//   multiplier    in   operand B, captured on acceptance
//   busy          out  high while running
//   done          out  one-cycle pulse, product valid
//   product       out  registered result, held until the next result
// ----------------------------------------------------------------------------
module multiplier_sequential
    import multiplier_sequential_pkg::*;
#(
    parameter int unsigned MCAND_WIDTH  = 8,
    parameter int unsigned MPLIER_WIDTH = 8
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    input  logic [MCAND_WIDTH-1:0]            multiplicand,
    input  logic [MPLIER_WIDTH-1:0]           multiplier,
    output logic                              busy,
    output logic                              done,
    output logic [MCAND_WIDTH+MPLIER_WIDTH-1:0] product
);

    localparam int unsigned CW = count_width(MPLIER_WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(MPLIER_WIDTH - 1);

    mul_state_e              state;
    logic [MCAND_WIDTH-1:0]  mcand_reg;
    logic [MPLIER_WIDTH-1:0] mplier_reg;
    logic [MCAND_WIDTH-1:0]  acc_hi;
    logic [MPLIER_WIDTH-1:0] acc_lo;
    logic [CW-1:0]           count;

    logic [MCAND_WIDTH-1:0]  addend;
    logic [MCAND_WIDTH-1:0]  sum;
    logic                    carry;
    logic [MCAND_WIDTH-1:0]  shift_hi;
    logic [MPLIER_WIDTH-1:0] shift_lo;

    // A zero addend when the multiplier bit is clear makes the adder output
    // equal acc_hi with no carry, so the shift needs no separate mux.
    assign addend = mplier_reg[0] ? mcand_reg : '0;

    adder_ripple_nbit #(
        .WIDTH (MCAND_WIDTH)
    ) u_adder (
        .carry_out (carry),
        .sum       (sum),
        .a         (acc_hi),
        .b         (addend),
        .carry_in  (1'b0)
    );

    // {carry, sum, acc_lo} shifted right by one; the carry becomes the MSB.
    assign shift_hi = {carry, sum[MCAND_WIDTH-1:1]};
    assign shift_lo = {sum[0], acc_lo[MPLIER_WIDTH-1:1]};

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= StIdle;
            busy       <= 1'b0;
            done       <= 1'b0;
            product    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            count      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle, StDone: begin
                    if (start) begin
                        state      <= StRun;
                        busy       <= 1'b1;
                        mcand_reg  <= multiplicand;
                        mplier_reg <= multiplier;
                        acc_hi     <= '0;
                        acc_lo     <= '0;
                        count      <= '0;
                    end else begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end
                end
                StRun: begin
                    acc_hi     <= shift_hi;
                    acc_lo     <= shift_lo;
                    mplier_reg <= mplier_reg >> 1;
                    count      <= count + CW'(1);
                    if (count == LAST_COUNT) begin
                        state   <= StDone;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        product <= {shift_hi, shift_lo};
                    end
                end
                default: begin
                    // Illegal encoding: fall back to idle.
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiplier_sequential.sv
module tb_multiplier_sequential;

    localparam int unsigned AW  = 8;
    localparam int unsigned BW  = 8;
    localparam int unsigned SAW = 3;
    localparam int unsigned SBW = 2;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic            reset;
    logic            start;
    logic [AW-1:0]   a;
    logic [BW-1:0]   b;
    logic            busy;
    logic            done;
    logic [AW+BW-1:0] product;

    logic             s_start;
    logic [SAW-1:0]   sa;
    logic [SBW-1:0]   sb;
    logic             s_busy;
    logic             s_done;
    logic [SAW+SBW-1:0] s_product;

    multiplier_sequential #(
        .MCAND_WIDTH  (AW),
        .MPLIER_WIDTH (BW)
    ) u_dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .multiplicand (a),
        .multiplier   (b),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    multiplier_sequential #(
        .MCAND_WIDTH  (SAW),
        .MPLIER_WIDTH (SBW)
    ) u_dut_small (
        .clock        (clock),
        .reset        (reset),
        .start        (s_start),
        .multiplicand (sa),
        .multiplier   (sb),
        .busy         (s_busy),
        .done         (s_done),
        .product      (s_product)
    );

    int cycle = 0;
    always @(posedge clock) cycle <= cycle + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] prod;
        int          t0;
    } exp_t;

    exp_t q[$];
    exp_t sq[$];
    exp_t e_big;
    exp_t e_small;
    int   last_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitors: pop expected results whenever a DUT presents done.
    always @(negedge clock) begin
        if (done) begin
            if (q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'(0));
            end else begin
                e_big = q.pop_front();
                check("product", 32'(product), e_big.prod);
                check("latency", 32'(cycle - e_big.t0), 32'(BW));
                check("busy_with_done", 32'(busy), 32'(0));
            end
            last_done = cycle;
        end
    end

    always @(negedge clock) begin
        if (s_done) begin
            if (sq.size() == 0) begin
                check("small_unexpected_done", 32'(s_done), 32'(0));
            end else begin
                e_small = sq.pop_front();
                check("small_product", 32'(s_product), e_small.prod);
                check("small_latency", 32'(cycle - e_small.t0), 32'(SBW));
            end
        end
    end

    // Start pulse on the big DUT; records the acceptance cycle if a result is expected.
    task automatic issue(input logic [AW-1:0] x, input logic [BW-1:0] y,
                         input logic [31:0] expected, input logic expect_it);
        exp_t e;
        @(negedge clock);
        start = 1'b1;
        a     = x;
        b     = y;
        @(posedge clock);
        #1;
        if (expect_it) begin
            e.prod = expected;
            e.t0   = cycle;
            q.push_back(e);
        end
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((q.size() != 0 || sq.size() != 0) && n < limit) begin
            @(negedge clock);
            n++;
        end
        if (q.size() != 0 || sq.size() != 0) begin
            check("drain_timeout", 32'(q.size() + sq.size()), 32'(0));
            q.delete();
            sq.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_done;
        int n;
        exp_t e;

        reset   = 1'b1;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        s_start = 1'b0;
        sa      = '0;
        sb      = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_done", 32'(done), 32'(0));
        check("reset_product", 32'(product), 32'(0));
        check("reset_small_product", 32'(s_product), 32'(0));
        reset = 1'b0;

        // Basic operation: 13 * 11 = 143, latency 8.
        issue(8'd13, 8'd11, 32'd143, 1'b1);
        drain(30);

        // Reset mid-run discards the operation and clears outputs.
        issue(8'hFF, 8'hFF, 32'd0, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("midrun_reset_busy", 32'(busy), 32'(0));
        check("midrun_reset_done", 32'(done), 32'(0));
        check("midrun_reset_product", 32'(product), 32'(0));
        reset = 1'b0;
        repeat (10) @(negedge clock);
        issue(8'd3, 8'd5, 32'd15, 1'b1);
        drain(30);

        // Corners.
        issue(8'hFF, 8'hFF, 32'h0000FE01, 1'b1);
        drain(30);
        issue(8'h00, 8'hFF, 32'h00000000, 1'b1);
        drain(30);
        issue(8'hFF, 8'h01, 32'h000000FF, 1'b1);
        drain(30);

        // Back-to-back: start held in the done cycle with new operands.
        issue(8'd7, 8'd9, 32'd63, 1'b1);
        n = 0;
        while (!done && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("b2b_first_done_seen", 32'(done), 32'(1));
        first_done = cycle;
        start = 1'b1;
        a     = 8'd2;
        b     = 8'd3;
        @(posedge clock);
        #1;
        e.prod = 32'd6;
        e.t0   = cycle;
        q.push_back(e);
        @(negedge clock);
        check("b2b_busy_reentered", 32'(busy), 32'(1));
        start = 1'b0;
        drain(30);
        check("b2b_gap", 32'(last_done - first_done), 32'(9));

        // Start pulsed mid-run with new operands must be ignored.
        issue(8'd13, 8'd11, 32'd143, 1'b1);
        repeat (3) @(negedge clock);
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
        @(negedge clock);
        start = 1'b0;
        drain(30);
        repeat (12) @(negedge clock);
        check("ignored_start_idle", 32'(busy), 32'(0));
        check("ignored_start_product_held", 32'(product), 32'd143);

        // Small instance: all 3x2-bit operand pairs.
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 4; j++) begin
                @(negedge clock);
                s_start = 1'b1;
                sa      = SAW'(i);
                sb      = SBW'(j);
                @(posedge clock);
                #1;
                e.prod = 32'(i * j);
                e.t0   = cycle;
                sq.push_back(e);
                @(negedge clock);
                s_start = 1'b0;
                drain(10);
            end
        end

        repeat (4) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
